// File: rtl/instr_decode_stage.sv
// instr_decode_stage: DEPTH-entry instruction/PC buffer with valid/ready handshake,
// flush, and combinational field split plus immediate generation of the head entry.
module instr_decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      imm_type,
   output logic            illegal
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [31:0]     r_instr [DEPTH];
   logic [XLEN-1:0] r_pc    [DEPTH];
   logic [PW-1:0]   r_wr, r_rd;
   logic [CW-1:0]   r_cnt;
   logic            w_push, w_pop, w_known;
   logic [31:0]     w_i;
   logic [2:0]      w_type;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign in_ready  = r_cnt != CW'(DEPTH);
   assign out_valid = r_cnt != '0;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   always_ff @(posedge clk)
      if (rst || flush) begin
         r_cnt <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
      end else begin
         if (w_push) begin
            r_instr[r_wr] <= in_instr;
            r_pc[r_wr]    <= in_pc;
            r_wr          <= nxt(r_wr);
         end
         if (w_pop) r_rd <= nxt(r_rd);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   // Gating the head word to zero makes every decoded field read 0 when empty.
   assign w_i    = out_valid ? r_instr[r_rd] : '0;
   assign out_pc = out_valid ? r_pc[r_rd] : '0;
   assign rs1    = w_i[19:15];
   assign rs2    = w_i[24:20];
   assign rd     = w_i[11:7];
   assign opcode = w_i[6:0];
   assign funct3 = w_i[14:12];
   assign funct7 = w_i[31:25];
   always_comb begin
      w_type  = 3'd0;
      w_known = 1'b1;
      case (w_i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: w_type = 3'd1;
         7'b0100011: w_type = 3'd2;
         7'b1100011: w_type = 3'd3;
         7'b0110111, 7'b0010111: w_type = 3'd4;
         7'b1101111: w_type = 3'd5;
         7'b0110011: w_type = 3'd0;
         default:    w_known = 1'b0;
      endcase
   end
   assign imm_type = w_type;
   assign illegal  = out_valid & ~w_known;
   assign imm = w_type == 3'd1 ? XLEN'($signed(w_i[31:20])) :
                w_type == 3'd2 ? XLEN'($signed({w_i[31:25], w_i[11:7]})) :
                w_type == 3'd3 ? XLEN'($signed({w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0})) :
                w_type == 3'd4 ? XLEN'($signed({w_i[31:12], 12'b0})) :
                w_type == 3'd5 ? XLEN'($signed({w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0})) :
                '0;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed scenarios plus random traffic against a queue-based model.
module tb_instr_decode_stage;
   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   logic            clk = 1'b0;
   logic            rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0]     in_instr = '0;
   logic [XLEN-1:0] in_pc = '0;
   logic            in_ready, out_valid, illegal;
   logic [XLEN-1:0] out_pc, imm;
   logic [4:0]      rs1, rs2, rd;
   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3, imm_type;
   int total = 0, bad = 0;
   typedef struct {logic [31:0] i; logic [31:0] pc;} ent_t;
   ent_t q[$];
   instr_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .imm(imm), .imm_type(imm_type), .illegal(illegal));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // Reference decode using plain integer arithmetic on the spec's bit rules.
   function automatic void ref_dec(input logic [31:0] i, output int t, output longint v, output bit ill);
      int op = int'(i[6:0]);
      t = 0; v = 0; ill = 0;
      if (op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F}) begin
         t = 1; v = longint'(i[31:20]); if (v >= 2048) v -= 4096;
      end else if (op == 7'h23) begin
         t = 2; v = longint'(i[31:25]) * 32 + longint'(i[11:7]); if (v >= 2048) v -= 4096;
      end else if (op == 7'h63) begin
         t = 3; v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
         if (v >= 4096) v -= 8192;
      end else if (op == 7'h37 || op == 7'h17) begin
         t = 4; v = longint'(i[31:12]) * 4096; if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
      end else if (op == 7'h6F) begin
         t = 5; v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
         if (v >= 1048576) v -= 2097152;
      end else if (op != 7'h33) ill = 1;
   endfunction
   task automatic check_all();
      logic [31:0] hi, hp;
      int t; longint v; bit ill, vld;
      vld = q.size() != 0;
      hi = vld ? q[0].i : 32'h0;
      hp = vld ? q[0].pc : 32'h0;
      ref_dec(hi, t, v, ill);
      chk("out_valid", 64'(out_valid), 64'(vld));
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("out_pc", 64'(out_pc), 64'(hp));
      chk("rs1", 64'(rs1), 64'(hi[19:15]));
      chk("rs2", 64'(rs2), 64'(hi[24:20]));
      chk("rd", 64'(rd), 64'(hi[11:7]));
      chk("opcode", 64'(opcode), 64'(hi[6:0]));
      chk("funct3", 64'(funct3), 64'(hi[14:12]));
      chk("funct7", 64'(funct7), 64'(hi[31:25]));
      chk("imm", 64'(imm), vld ? 64'(v[31:0]) : 64'h0);
      chk("imm_type", 64'(imm_type), vld ? 64'(t) : 64'h0);
      chk("illegal", 64'(illegal), 64'(vld && ill));
   endtask
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl, input bit r);
      bit push, pop;
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
      @(posedge clk);
      if (r || fl) q.delete();
      else begin
         push = v && q.size() < DEPTH;
         pop  = ordy && q.size() > 0;
         if (pop) void'(q.pop_front());
         if (push) q.push_back('{ins, pc});
      end
      #1;
      check_all();
   endtask
   logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
   initial begin
      logic [31:0] r;
      logic [6:0] op;
      int k;
      step(0, 0, 0, 0, 0, 1);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      step(1, 32'hFFF10093, 32'h100, 0, 0, 0);
      chk("addi_rd", 64'(rd), 1);
      chk("addi_rs1", 64'(rs1), 2);
      chk("addi_type", 64'(imm_type), 1);
      chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
      chk("addi_pc", 64'(out_pc), 64'h100);
      step(0, 0, 0, 1, 0, 0);
      step(1, 32'h00512423, 32'h200, 1, 0, 0);
      chk("sw_rs1", 64'(rs1), 2);
      chk("sw_rs2", 64'(rs2), 5);
      chk("sw_imm", 64'(imm), 8);
      chk("sw_type", 64'(imm_type), 2);
      step(1, 32'hFE000EE3, 32'h204, 1, 0, 0);
      chk("beq_imm", 64'(imm), 64'hFFFFFFFC);
      chk("beq_type", 64'(imm_type), 3);
      step(1, 32'h123451B7, 32'h208, 1, 0, 0);
      chk("lui_rd", 64'(rd), 3);
      chk("lui_imm", 64'(imm), 64'h12345000);
      chk("lui_type", 64'(imm_type), 4);
      step(0, 0, 0, 1, 0, 0);
      step(1, 32'h00100093, 32'h300, 0, 0, 0);
      step(1, 32'h00200093, 32'h304, 0, 0, 0);
      chk("full_in_ready", 64'(in_ready), 0);
      step(1, 32'h00300093, 32'h308, 0, 0, 0);
      chk("held_head_pc", 64'(out_pc), 64'h300);
      step(0, 0, 0, 1, 0, 0);
      chk("drain_pc1", 64'(out_pc), 64'h304);
      chk("drain_in_ready", 64'(in_ready), 1);
      step(0, 0, 0, 1, 0, 0);
      chk("drain_empty", 64'(out_valid), 0);
      step(1, 32'h00100093, 32'h400, 0, 0, 0);
      step(1, 32'h00200093, 32'h404, 0, 0, 0);
      step(1, 32'h00300093, 32'h408, 1, 1, 0);
      chk("flush_valid", 64'(out_valid), 0);
      step(0, 0, 0, 0, 0, 0);
      chk("flush_stays_empty", 64'(out_valid), 0);
      step(1, 32'h00100093, 32'h500, 0, 0, 0);
      step(1, 32'h00200093, 32'h504, 0, 0, 0);
      step(1, 32'h00300093, 32'h508, 1, 0, 1);
      chk("rst_mid_valid", 64'(out_valid), 0);
      chk("rst_mid_ready", 64'(in_ready), 1);
      chk("rst_mid_imm", 64'(imm), 0);
      chk("rst_mid_pc", 64'(out_pc), 0);
      step(1, 32'h00000010, 32'h600, 0, 0, 0);
      chk("ill_flag", 64'(illegal), 1);
      chk("ill_type", 64'(imm_type), 0);
      chk("ill_imm", 64'(imm), 0);
      step(0, 0, 0, 1, 0, 0);
      chk("ill_popped", 64'(out_valid), 0);
      for (int n = 0; n < 600; n++) begin
         r = $urandom();
         k = $urandom_range(0, 11);
         op = k == 11 ? r[6:0] : ops[k];
         step($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom(), $urandom_range(0, 2) != 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
